hv_dac_loader: RTL and testbench
================================

# hv_dac_loader

Serial loader for the APD bias high-voltage DACs on the FEC. It consumes the 32 bias setpoints and the single-cycle update strobe produced by the DTC command decoder. On each update it snapshots all setpoints and shifts them into two 16-channel 12-bit DACs over a SPI-style write-only link, then pulses LDAC so all outputs change together.

## Interface

Parameters:
- CLK_DIV, 4: dtc_clk cycles per SCLK half-period; legal values 1..255.
- HV_MAX, 12'hE00: clamp ceiling, used only when HV_DAC_CLAMP_EN is defined.

Ports:
- dtc_clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- hv_update  in  1  single-cycle update request from the command decoder.
- hv_dac_data  in  12 x [31:0]  per-channel bias setpoints; held stable by the decoder between writes.
- dac_sclk  out  1  serial clock; idles low.
- dac_sdi  out  1  serial data, MSB first; changes on SCLK falling edges.
- dac_cs_n  out  2  chip selects, active low; bit 0 is channels 0-15, bit 1 is channels 16-31.
- dac_ldac_n  out  1  load strobe, active low.
- busy  out  1  high while a frame sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- update_cnt  out  16  count of completed sequences; wraps at 16'hFFFF.

## Operation

- States: IDLE, CS_SETUP, SCLK_HI, SCLK_LO, CS_HOLD, LDAC, DONE. A single divider counter runs from 0 to CLK_DIV-1 and paces every timed state.
- IDLE: all outputs idle. A hv_update sampled high does three things on the next edge:
  - copies all 32 setpoints into a shadow array;
  - clears ch (5 bits);
  - enters CS_SETUP.
- Frame word per channel is {ch[3:0], value[11:0]}, 16 bits, MSB first. ch[4] selects which cs_n bit drives low.
- CS_SETUP: the selected cs_n is low and sdi = word[15]. Lasts CLK_DIV cycles, then goes to SCLK_HI.
- SCLK_HI: sclk = 1 for CLK_DIV cycles, then goes to SCLK_LO.
- SCLK_LO: sclk = 0 for CLK_DIV cycles.
  - sdi moves to the next bit on entry.
  - After bit 0, the state goes to CS_HOLD; otherwise it returns to SCLK_HI.
- CS_HOLD: both cs_n high for CLK_DIV cycles.
  - If ch = 31, go to LDAC.
  - Otherwise increment ch and go to CS_SETUP.
- LDAC: ldac_n low for 2*CLK_DIV cycles, then go to DONE.
- DONE: lasts one cycle.
  - done = 1 and busy = 0.
  - update_cnt increments.
  - If the pending flag is set, clear it, re-snapshot the setpoints, and go to CS_SETUP; otherwise go to IDLE.
- hv_update while busy sets the pending flag. Multiple requests coalesce into a single re-run. Channels already in flight always use the original snapshot.
- hv_update arriving in the same cycle as DONE is treated as pending, which gives an immediate re-run.
- Shadow values do not change during a sequence, even if the decoder rewrites hv_dac_data.

## Timing

- Reset values: dac_sclk = 0, dac_sdi = 0, dac_cs_n = 2'b11, dac_ldac_n = 1, busy = 0, done = 0, update_cnt = 0. Also cleared: pending = 0, ch = 0, state = IDLE.
- Reset asserted mid-sequence returns all outputs to their reset values on the next edge. No partial LDAC is issued, and the pending flag is discarded.
- Latency: busy and the first cs_n low both occur on the edge after hv_update is sampled.
- Per channel: 34*CLK_DIV cycles (CS_SETUP CLK_DIV + 16 bits x 2*CLK_DIV + CS_HOLD CLK_DIV).
- Full sequence: busy is high for exactly 1090*CLK_DIV cycles (32 x 34 + 2). With CLK_DIV = 4 this is 4360 cycles.
- done fires in the first cycle with busy = 0. On a re-run, busy drops for only that one cycle.
- The DAC samples sdi on the rising edge of sclk. sdi is stable for CLK_DIV cycles either side of each rising edge.
- The two chip selects are never low at the same time.

## Configuration

- HV_DAC_CLAMP_EN defined: each value is min(hv_dac_data[i], HV_MAX), applied at snapshot time as an unsigned 12-bit compare.
- HV_DAC_CLAMP_EN undefined: values pass through unmodified, and HV_MAX is unused.

## Test plan

- Reset release with no stimulus -> outputs hold reset values for 10000 cycles, and no sclk edges occur.
- CLK_DIV = 4, ch0 = 12'h123, ch31 = 12'hABC, hv_update pulse:
  - first frame on cs_n[0] decodes to 16'h0123;
  - last frame on cs_n[1] decodes to 16'hFABC;
  - ldac_n is low for 8 cycles;
  - busy is high for 4360 cycles;
  - done pulses once and update_cnt = 1.
- Three hv_update pulses during a sequence -> exactly one re-run, update_cnt = 2, busy low for 1 cycle between runs.
- Rewrite hv_dac_data[5] mid-sequence -> the current run sends the old value; a new update sends the new value.
- Reset at channel 10 mid-bit -> next cycle cs_n = 2'b11, sclk = 0, busy = 0, and no LDAC pulse.
- With HV_DAC_CLAMP_EN: ch3 = 12'hFFF -> frame 16'h3E00. Without it: frame 16'h3FFF.

Source files
------------

// File: rtl/hv_dac_loader.sv
// Serial loader for the two 16-channel 12-bit APD bias DACs: snapshots 32 setpoints and shifts them out, then pulses LDAC.
// Optional feature: define HV_DAC_CLAMP_EN to clamp every setpoint to HV_MAX at snapshot time.
module hv_dac_loader #(
   parameter int          CLK_DIV = 4,
   parameter logic [11:0] HV_MAX  = 12'hE00
) (
   input  logic              dtc_clk,
   input  logic              rst,
   input  logic              hv_update,
   input  logic [31:0][11:0] hv_dac_data,
   output logic              dac_sclk,
   output logic              dac_sdi,
   output logic [1:0]        dac_cs_n,
   output logic              dac_ldac_n,
   output logic              busy,
   output logic              done,
   output logic [15:0]       update_cnt
);

   typedef enum logic [2:0] {
      IDLE, CS_SETUP, SCLK_HI, SCLK_LO, CS_HOLD, LDAC, DONE
   } state_t;

   localparam logic [8:0] DIV_LAST  = 9'(CLK_DIV - 1);
   localparam logic [8:0] LDAC_LAST = 9'(2 * CLK_DIV - 1);

   state_t      state;
   logic [8:0]  div_cnt;
   logic [4:0]  bit_idx;
   logic [4:0]  ch;
   logic [4:0]  next_ch;
   logic        pending;
   logic        take_snap;
   logic [11:0] shadow [32];
   logic [15:0] cur_word;
   logic [3:0]  nxt_bit;
   logic [11:0] hv_max_unused;

   // The ceiling only takes effect in the clamping build.
   assign hv_max_unused = HV_MAX;

   function automatic logic [11:0] clamp(input logic [11:0] v);
`ifdef HV_DAC_CLAMP_EN
      return (v > HV_MAX) ? HV_MAX : v;
`else
      return v;
`endif
   endfunction

   assign take_snap = !rst && ((state == IDLE && hv_update) ||
                               (state == DONE && (pending || hv_update)));
   assign cur_word  = {ch[3:0], shadow[ch]};
   assign nxt_bit   = bit_idx[3:0] - 4'd1;
   assign next_ch   = ch + 5'd1;

   always_ff @(posedge dtc_clk) begin
      if (take_snap) begin
         for (int i = 0; i < 32; i++) shadow[i] <= clamp(hv_dac_data[i]);
      end
   end

   // bit_idx wraps to 5'h1F once bit 0 has been clocked, marking the end of the frame.
   always_ff @(posedge dtc_clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_idx    <= '0;
         ch         <= '0;
         pending    <= 1'b0;
         dac_sclk   <= 1'b0;
         dac_sdi    <= 1'b0;
         dac_cs_n   <= 2'b11;
         dac_ldac_n <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         update_cnt <= '0;
      end else begin
         if (busy && hv_update) pending <= 1'b1;
         case (state)
            IDLE: begin
               if (hv_update) begin
                  ch       <= '0;
                  div_cnt  <= '0;
                  state    <= CS_SETUP;
                  dac_cs_n <= 2'b10;
                  dac_sdi  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CS_SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  state    <= SCLK_HI;
                  dac_sclk <= 1'b1;
                  bit_idx  <= 5'd15;
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end
            SCLK_HI: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  state    <= SCLK_LO;
                  dac_sclk <= 1'b0;
                  bit_idx  <= bit_idx - 5'd1;
                  dac_sdi  <= (bit_idx == 5'd0) ? 1'b0 : cur_word[nxt_bit];
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end
            SCLK_LO: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_idx == 5'h1F) begin
                     state    <= CS_HOLD;
                     dac_cs_n <= 2'b11;
                  end else begin
                     state    <= SCLK_HI;
                     dac_sclk <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end
            CS_HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (ch == 5'd31) begin
                     state      <= LDAC;
                     dac_ldac_n <= 1'b0;
                  end else begin
                     ch       <= next_ch;
                     state    <= CS_SETUP;
                     dac_cs_n <= next_ch[4] ? 2'b01 : 2'b10;
                     dac_sdi  <= next_ch[3];
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end
            LDAC: begin
               if (div_cnt == LDAC_LAST) begin
                  div_cnt    <= '0;
                  state      <= DONE;
                  dac_ldac_n <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  update_cnt <= update_cnt + 16'd1;
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end
            DONE: begin
               done    <= 1'b0;
               div_cnt <= '0;
               if (pending || hv_update) begin
                  pending  <= 1'b0;
                  ch       <= '0;
                  state    <= CS_SETUP;
                  dac_cs_n <= 2'b10;
                  dac_sdi  <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hv_dac_loader.sv
// Self-checking bench for hv_dac_loader: timeline model checked every cycle plus decoded-frame literal checks.
// Honours HV_DAC_CLAMP_EN so the same bench covers both builds.
module tb_hv_dac_loader;

   localparam int D = 4;
   localparam int SEQ_LEN = 1090 * D;
   localparam logic [11:0] HV_MAX = 12'hE00;
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

   logic              dtc_clk;
   logic              rst;
   logic              hv_update;
   logic [31:0][11:0] hv_dac_data;
   logic              dac_sclk, dac_sdi, dac_ldac_n, busy, done;
   logic [1:0]        dac_cs_n;
   logic [15:0]       update_cnt;

   int checks = 0;
   int errors = 0;

   int          mode = M_IDLE;
   int          k = 0;
   bit          pend = 0;
   logic [15:0] exp_cnt = '0;
   logic [11:0] snap [32];

   logic [15:0] frames [$];
   int          frame_cs [$];
   logic [15:0] shift_reg = '0;
   logic        prev_sclk = 1'b0;
   logic        prev_busy = 1'b0;
   logic [1:0]  prev_cs = 2'b11;
   int sclk_edges = 0, done_cnt = 0, ldac_low = 0, busy_total = 0;
   int busy_run = 0, low_run = 0, last_busy_len = 0, last_low_len = 0;

   hv_dac_loader #(.CLK_DIV(D), .HV_MAX(HV_MAX)) dut (
      .dtc_clk(dtc_clk), .rst(rst), .hv_update(hv_update), .hv_dac_data(hv_dac_data),
      .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .dac_cs_n(dac_cs_n), .dac_ldac_n(dac_ldac_n),
      .busy(busy), .done(done), .update_cnt(update_cnt)
   );

   initial dtc_clk = 1'b0;
   always #5 dtc_clk = ~dtc_clk;

   function automatic logic [11:0] model_clamp(input logic [11:0] v);
`ifdef HV_DAC_CLAMP_EN
      return (v > HV_MAX) ? HV_MAX : v;
`else
      return v;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus();
      @(negedge dtc_clk);
      hv_update = 1'b1;
      @(negedge dtc_clk);
      hv_update = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge dtc_clk);
         n++;
      end
      checkOutput("done_wait", 32'(done_cnt >= target), 32'd1);
   endtask

   // Timeline model: position k within the 1090*D-cycle sequence fully determines the bus.
   task automatic monitor_loop();
      logic              s_rst, s_upd;
      logic [31:0][11:0] s_data;
      logic              e_busy, e_done, e_sclk, e_ldac, e_sdi, sdi_chk;
      logic [1:0]        e_cs;
      logic [15:0]       w;
      logic [4:0]        cc;
      int                c, j, b, ph;
      forever begin
         @(posedge dtc_clk);
         s_rst = rst;
         s_upd = hv_update;
         s_data = hv_dac_data;
         if (s_rst) begin
            mode = M_IDLE; pend = 0; exp_cnt = '0;
         end else if (mode == M_IDLE) begin
            if (s_upd) begin
               for (int i = 0; i < 32; i++) snap[i] = model_clamp(s_data[i]);
               k = 0; mode = M_RUN;
            end
         end else if (mode == M_RUN) begin
            if (s_upd) pend = 1;
            if (k == SEQ_LEN - 1) begin
               mode = M_DONE; exp_cnt = exp_cnt + 16'd1;
            end else begin
               k++;
            end
         end else begin
            if (pend || s_upd) begin
               pend = 0;
               for (int i = 0; i < 32; i++) snap[i] = model_clamp(s_data[i]);
               k = 0; mode = M_RUN;
            end else begin
               mode = M_IDLE;
            end
         end
         #1;
         e_busy = 0; e_done = 0; e_cs = 2'b11; e_sclk = 0; e_ldac = 1; e_sdi = 0; sdi_chk = 1;
         if (mode == M_RUN) begin
            e_busy = 1;
            if (k < 1088 * D) begin
               c = k / (34 * D);
               j = k % (34 * D);
               cc = 5'(c);
               w = {cc[3:0], snap[c]};
               if (j < D) begin
                  e_cs = cc[4] ? 2'b01 : 2'b10;
                  e_sdi = w[15];
               end else if (j < 33 * D) begin
                  e_cs = cc[4] ? 2'b01 : 2'b10;
                  b = (j - D) / (2 * D);
                  ph = (j - D) % (2 * D);
                  if (ph < D) begin
                     e_sclk = 1; e_sdi = w[15 - b];
                  end else if (b < 15) begin
                     e_sdi = w[14 - b];
                  end else begin
                     sdi_chk = 0;
                  end
               end else begin
                  sdi_chk = 0;
               end
            end else begin
               e_ldac = 0; sdi_chk = 0;
            end
         end else if (mode == M_DONE) begin
            e_done = 1;
         end
         checkOutput("busy", 32'(busy), 32'(e_busy));
         checkOutput("done", 32'(done), 32'(e_done));
         checkOutput("cs_n", 32'(dac_cs_n), 32'(e_cs));
         checkOutput("sclk", 32'(dac_sclk), 32'(e_sclk));
         checkOutput("ldac_n", 32'(dac_ldac_n), 32'(e_ldac));
         checkOutput("update_cnt", 32'(update_cnt), 32'(exp_cnt));
         if (sdi_chk) checkOutput("sdi", 32'(dac_sdi), 32'(e_sdi));

         if (!prev_sclk && dac_sclk) begin
            shift_reg = {shift_reg[14:0], dac_sdi};
            sclk_edges++;
         end
         if (prev_cs != 2'b11 && dac_cs_n == 2'b11) begin
            frames.push_back(shift_reg);
            frame_cs.push_back(prev_cs == 2'b10 ? 0 : (prev_cs == 2'b01 ? 1 : 2));
         end
         if (!dac_ldac_n) ldac_low++;
         if (done) done_cnt++;
         if (busy) begin
            busy_total++;
            busy_run++;
            if (!prev_busy) begin last_low_len = low_run; low_run = 0; end
         end else begin
            low_run++;
            if (prev_busy) begin last_busy_len = busy_run; busy_run = 0; end
         end
         prev_sclk = dac_sclk;
         prev_cs = dac_cs_n;
         prev_busy = busy;
      end
   endtask

   initial begin
      logic [15:0] exp_ch3;
      int base;
`ifdef HV_DAC_CLAMP_EN
      exp_ch3 = 16'h3E00;
`else
      exp_ch3 = 16'h3FFF;
`endif
      rst = 1'b1;
      hv_update = 1'b0;
      for (int i = 0; i < 32; i++) hv_dac_data[i] = 12'(i * 37 + 16);
      hv_dac_data[0] = 12'h123;
      hv_dac_data[3] = 12'hFFF;
      hv_dac_data[5] = 12'h555;
      hv_dac_data[31] = 12'hABC;
      fork
         monitor_loop();
      join_none

      $display("[TB] reset and idle");
      repeat (3) @(negedge dtc_clk);
      checkOutput("rst_cs_n", 32'(dac_cs_n), 32'h3);
      checkOutput("rst_ldac_n", 32'(dac_ldac_n), 32'h1);
      checkOutput("rst_cnt", 32'(update_cnt), 32'h0);
      rst = 1'b0;
      sclk_edges = 0; busy_total = 0;
      repeat (10000) @(negedge dtc_clk);
      checkOutput("idle_sclk_edges", 32'(sclk_edges), 32'd0);
      checkOutput("idle_busy", 32'(busy_total), 32'd0);

      $display("[TB] single sequence");
      frames.delete(); frame_cs.delete(); ldac_low = 0;
      applyStimulus();
      wait_done(1, SEQ_LEN + 100);
      checkOutput("frame_count", 32'(frames.size()), 32'd32);
      if (frames.size() == 32) begin
         checkOutput("frame0", 32'(frames[0]), 32'h0123);
         checkOutput("frame0_cs", 32'(frame_cs[0]), 32'd0);
         checkOutput("frame31", 32'(frames[31]), 32'hFABC);
         checkOutput("frame31_cs", 32'(frame_cs[31]), 32'd1);
         checkOutput("frame3_clamp", 32'(frames[3]), 32'(exp_ch3));
         checkOutput("frame5", 32'(frames[5]), 32'h5555);
      end
      checkOutput("ldac_len", 32'(ldac_low), 32'd8);
      checkOutput("busy_len", 32'(last_busy_len), 32'd4360);
      checkOutput("done_pulses", 32'(done_cnt), 32'd1);
      checkOutput("update_cnt_1", 32'(update_cnt), 32'd1);

      $display("[TB] coalesced re-run");
      frames.delete(); frame_cs.delete();
      base = done_cnt;
      applyStimulus();
      repeat (100) @(negedge dtc_clk);
      applyStimulus();
      repeat (1500) @(negedge dtc_clk);
      applyStimulus();
      repeat (1500) @(negedge dtc_clk);
      applyStimulus();
      wait_done(base + 2, 2 * SEQ_LEN + 200);
      repeat (50) @(negedge dtc_clk);
      checkOutput("rerun_dones", 32'(done_cnt), 32'(base + 2));
      checkOutput("rerun_cnt", 32'(update_cnt), 32'd3);
      checkOutput("rerun_gap", 32'(last_low_len), 32'd1);
      checkOutput("rerun_busy_len", 32'(last_busy_len), 32'd4360);
      checkOutput("rerun_frames", 32'(frames.size()), 32'd64);
      checkOutput("rerun_idle", 32'(busy), 32'd0);

      $display("[TB] setpoint rewrite mid-sequence");
      frames.delete(); frame_cs.delete();
      base = done_cnt;
      applyStimulus();
      repeat (300) @(negedge dtc_clk);
      hv_dac_data[5] = 12'hAAA;
      wait_done(base + 1, SEQ_LEN + 100);
      applyStimulus();
      wait_done(base + 2, SEQ_LEN + 100);
      checkOutput("rewrite_frames", 32'(frames.size()), 32'd64);
      if (frames.size() == 64) begin
         checkOutput("rewrite_old", 32'(frames[5]), 32'h5555);
         checkOutput("rewrite_new", 32'(frames[37]), 32'h5AAA);
      end

      $display("[TB] reset mid-sequence");
      applyStimulus();
      repeat (500) @(negedge dtc_clk);
      applyStimulus();
      repeat (897) @(negedge dtc_clk);
      checkOutput("pre_rst_cs_n", 32'(dac_cs_n), 32'h2);
      checkOutput("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge dtc_clk);
      checkOutput("mid_rst_cs_n", 32'(dac_cs_n), 32'h3);
      checkOutput("mid_rst_sclk", 32'(dac_sclk), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_cnt", 32'(update_cnt), 32'd0);
      rst = 1'b0;
      ldac_low = 0; busy_total = 0;
      repeat (300) @(negedge dtc_clk);
      checkOutput("post_rst_ldac", 32'(ldac_low), 32'd0);
      checkOutput("post_rst_busy", 32'(busy_total), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
